// File: rtl/sonar_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranging sequencer.
// Holds the FSM state encoding, the per-channel result record and the saturation value.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GUARD
    } sonar_state_e;

    typedef struct packed {
        logic        valid;
        logic        timeout;
        logic [29:0] count;
    } sonar_result_t;

    localparam logic [29:0] COUNT_SAT = 30'h3FFF_FFFF;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sonar_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals.
// Each bit is synchronized on its own; there is no bus coherency between bits.
module sonar_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sonar_array.sv
// Round-robin ultrasonic ranging sequencer: triggers one channel at a time, times its
// echo with a shared counter and keeps a {valid, timeout, count} record per channel.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | scan stopped; waits for enable
// TRIG       | trigger[ch] high for TRIG_CYC cycles
// WAIT_RISE  | waiting for echo[ch] to rise, bounded by RISE_TO_CYC
// MEASURE    | counting echo[ch] high cycles, bounded by ECHO_TO_CYC
// GUARD      | crosstalk gap of GUARD_CYC cycles before the next channel
module sonar_array
    import sonar_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TRIG_CYC    = 500,
    parameter int RISE_TO_CYC = 50_000,
    parameter int ECHO_TO_CYC = 1_500_000,
    parameter int GUARD_CYC   = 500_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [N_CH-1:0] echo,
    output logic [N_CH-1:0] trigger,
    input  logic [7:0]      rd_sel,
    output logic [31:0]     rd_data,
    output logic            scan_done
);

    localparam int CNT_MAX = max_of(max_of(TRIG_CYC, GUARD_CYC), max_of(RISE_TO_CYC, ECHO_TO_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    sonar_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    sonar_result_t    res_q [N_CH];

    logic [N_CH-1:0] echo_s;
    logic            echo_cur;
    logic            last_ch;
    logic            guard_done;
    logic            wr_en;
    sonar_result_t   wr_val;

    sonar_sync #(.W(N_CH)) u_echo_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (echo),
        .q_o     (echo_s)
    );

    assign echo_cur   = echo_s[ch_q];
    assign last_ch    = (ch_q == CH_W'(N_CH - 1));
    assign guard_done = (cnt_q == CNT_W'(GUARD_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
        end
    end

    // Whole record written in one cycle so a readback never sees a mixed old/new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                res_q[i] <= '0;
            end
        end else if (wr_en) begin
            res_q[ch_q] <= wr_val;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        wr_en   = 1'b0;
        wr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    ch_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                // The cycle that detects the rise is itself the first echo-high cycle.
                if (echo_cur) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_MEASURE;
                end else if (cnt_q == CNT_W'(RISE_TO_CYC - 1)) begin
                    wr_en          = 1'b1;
                    wr_val.valid   = 1'b1;
                    wr_val.timeout = 1'b1;
                    wr_val.count   = COUNT_SAT;
                    cnt_d          = '0;
                    state_d        = ST_GUARD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!echo_cur) begin
                    wr_en          = 1'b1;
                    wr_val.valid   = 1'b1;
                    wr_val.timeout = 1'b0;
                    wr_val.count   = 30'(cnt_q);
                    cnt_d          = '0;
                    state_d        = ST_GUARD;
                end else if (cnt_q == CNT_W'(ECHO_TO_CYC)) begin
                    wr_en          = 1'b1;
                    wr_val.valid   = 1'b1;
                    wr_val.timeout = 1'b1;
                    wr_val.count   = COUNT_SAT;
                    cnt_d          = '0;
                    state_d        = ST_GUARD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (guard_done) begin
                    cnt_d = '0;
                    if (!enable) begin
                        ch_d    = '0;
                        state_d = ST_IDLE;
                    end else if (last_ch) begin
                        ch_d    = '0;
                        state_d = ST_TRIG;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_TRIG;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ch_d    = '0;
            end
        endcase
    end

    always_comb begin
        trigger = '0;
        if (state_q == ST_TRIG) begin
            trigger[ch_q] = 1'b1;
        end
        scan_done = (state_q == ST_GUARD) && guard_done && last_ch;
    end

    always_comb begin
        rd_data = '0;
        if (rd_sel < 8'(N_CH)) begin
            rd_data = res_q[rd_sel[CH_W-1:0]];
        end
    end

endmodule

// File: tb/tb_sonar_array.sv
// Randomized bench for sonar_array: per-channel echo drivers react to the triggers and a
// rule-based model predicts each channel's stored record at the end of every scan.
module tb_sonar_array;

    localparam int N_CH        = 4;
    localparam int TRIG_CYC    = 5;
    localparam int RISE_TO_CYC = 20;
    localparam int ECHO_TO_CYC = 100;
    localparam int GUARD_CYC   = 10;
    localparam int NS          = 5;
    localparam int LIM         = 3000;

    typedef struct {
        int mode;   // 0 normal echo, 1 never rises, 2 overlong echo, 3 stuck high from trigger
        int d;
        int w;
    } plan_t;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable  = 1'b0;
    logic [N_CH-1:0]   echo    = '0;
    logic [N_CH-1:0]   trigger;
    logic [7:0]        rd_sel  = '0;
    logic [31:0]       rd_data;
    logic              scan_done;

    int n_checks = 0;
    int n_errors = 0;
    int sd_cnt   = 0;

    plan_t       plan [NS][N_CH];
    logic [31:0] expv [NS][N_CH];

    sonar_array #(
        .N_CH        (N_CH),
        .TRIG_CYC    (TRIG_CYC),
        .RISE_TO_CYC (RISE_TO_CYC),
        .ECHO_TO_CYC (ECHO_TO_CYC),
        .GUARD_CYC   (GUARD_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .echo      (echo),
        .trigger   (trigger),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .scan_done (scan_done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A channel reports its echo width only when the line returns inside the echo limit.
    function automatic logic [31:0] exp_result(input plan_t p);
        if (p.mode == 0 && p.w < ECHO_TO_CYC) return {1'b1, 1'b0, 30'(p.w)};
        return 32'hFFFF_FFFF;
    endfunction

    always @(negedge clk) begin
        if (scan_done) sd_cnt++;
        if (reset_n && trigger != '0) chk("trig_onehot", 32'($onehot(trigger)), 32'd1);
    end

    task automatic wait_rise(input int k);
        int n = 0;
        while (!trigger[k] && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("trig%0d_seen", k), 32'(trigger[k]), 32'd1);
    endtask

    task automatic drive_one(input int k, input plan_t p, input int drop_after);
        int n;
        wait_rise(k);
        if (!trigger[k]) return;
        if (p.mode == 3) echo[k] = 1'b1;
        n = 0;
        while (trigger[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("trig%0d_width", k), 32'(n), 32'(TRIG_CYC));
        if (p.mode == 1) return;
        if (p.mode == 3) begin
            repeat (ECHO_TO_CYC + 5 + p.d) @(negedge clk);
            echo[k] = 1'b0;
            return;
        end
        repeat (p.d) @(negedge clk);
        echo[k] = 1'b1;
        for (int i = 0; i < p.w; i++) begin
            @(negedge clk);
            if (i == drop_after) enable = 1'b0;
        end
        echo[k] = 1'b0;
    endtask

    task automatic read_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev [N_CH];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int c = 0; c < N_CH; c++) begin
            rd_sel = 8'(c);
            #1;
            chk($sformatf("%s_ch%0d", tag, c), rd_data, ev[c]);
        end
    endtask

    initial begin
        int          n;
        int          sd0;
        logic        seen2;
        logic        any_trig;
        plan_t       p0;
        plan_t       p1;

        // Directed first scan, then random ones.
        plan[0][0] = '{0, 3, 40};
        plan[0][1] = '{2, 0, 200};
        plan[0][2] = '{1, 0, 0};
        plan[0][3] = '{0, 5, 60};
        for (int s = 1; s < NS; s++) begin
            for (int c = 0; c < N_CH; c++) begin
                plan[s][c].mode = int'($urandom_range(0, 3));
                plan[s][c].d    = int'($urandom_range(0, 12));
                plan[s][c].w    = (plan[s][c].mode == 0) ? int'($urandom_range(1, 99))
                                                         : int'($urandom_range(101, 130));
            end
        end
        for (int s = 0; s < NS; s++)
            for (int c = 0; c < N_CH; c++)
                expv[s][c] = exp_result(plan[s][c]);

        repeat (3) @(negedge clk);
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        read_all("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        rd_sel = 8'd5;
        #1 chk("rst_sel5", rd_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_trig", 32'(trigger), 32'd0);

        for (int k = 0; k < N_CH; k++) begin
            fork
                automatic int kk = k;
                begin
                    for (int s = 0; s < NS; s++) drive_one(kk, plan[s][kk], -1);
                end
            join_none
        end

        enable = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (s == NS - 1) begin
                n = 0;
                while (!trigger[N_CH-1] && n < LIM) begin
                    @(negedge clk);
                    n++;
                end
                enable = 1'b0;
            end
            n = 0;
            while (!scan_done && n < LIM) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("scan%0d_done_seen", s), 32'(scan_done), 32'd1);
            read_all($sformatf("scan%0d", s), expv[s][0], expv[s][1], expv[s][2], expv[s][3]);
            chk($sformatf("scan%0d_done_count", s), 32'(sd_cnt), 32'(s + 1));
            @(negedge clk);
        end
        wait fork;
        repeat (5) @(negedge clk);
        chk("after_scans_idle", 32'(trigger), 32'd0);

        // Enable dropped in the middle of channel 1's echo.
        sd0    = sd_cnt;
        p0     = '{0, 2, 20};
        p1     = '{0, 2, 60};
        enable = 1'b1;
        drive_one(0, p0, -1);
        drive_one(1, p1, 10);
        seen2    = 1'b0;
        any_trig = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (trigger[2]) seen2 = 1'b1;
            if (trigger != '0) any_trig = 1'b1;
        end
        chk("drop_no_trig2", 32'(seen2), 32'd0);
        chk("drop_stays_idle", 32'(any_trig), 32'd0);
        chk("drop_no_scan_done", 32'(sd_cnt), 32'(sd0));
        rd_sel = 8'd0;
        #1 chk("drop_ch0", rd_data, exp_result(p0));
        rd_sel = 8'd1;
        #1 chk("drop_ch1", rd_data, exp_result(p1));

        // Reset asserted while channel 0 is triggering.
        @(negedge clk);
        enable = 1'b1;
        wait_rise(0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midtrig_rst_trigger", 32'(trigger), 32'd0);
        chk("midtrig_rst_scan_done", 32'(scan_done), 32'd0);
        read_all("midtrig_rst", 32'd0, 32'd0, 32'd0, 32'd0);
        rd_sel = 8'd7;
        #1 chk("midtrig_rst_sel7", rd_data, 32'd0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_glitch", 32'(trigger), 32'd0);
        end
        enable = 1'b1;
        p0 = '{1, 0, 0};
        drive_one(0, p0, -1);
        enable = 1'b0;
        repeat (RISE_TO_CYC + GUARD_CYC + 10) @(negedge clk);
        rd_sel = 8'd0;
        #1 chk("resume_ch0", rd_data, exp_result(p0));
        chk("resume_idle", 32'(trigger), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sonar_array.md
SONAR_ARRAY -- requirements
Module: sonar_array

Interface
REQ-001 Parameter N_CH, default 4, number of ultrasonic channels (1..16).
REQ-002 Parameter TRIG_CYC, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-003 Parameter RISE_TO_CYC, default 50_000, maximum wait from trigger fall to echo rise.
REQ-004 Parameter ECHO_TO_CYC, default 1_500_000, maximum echo-high duration (30 ms).
REQ-005 Parameter GUARD_CYC, default 500_000, idle gap between successive channels (crosstalk guard).
REQ-006 clk  in  1  system clock, 50 MHz.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  level; high = run continuous round-robin scan.
REQ-009 echo  in  N_CH  raw asynchronous echo lines, one per channel.
REQ-010 trigger  out  N_CH  trigger pulses, one-hot or all zero.
REQ-011 rd_sel  in  8  channel select for readback (SPI DataAddr offset).
REQ-012 rd_data  out  32  {valid, timeout, count[29:0]} of channel rd_sel; 0 if rd_sel >= N_CH.
REQ-013 scan_done  out  1  one-cycle pulse when the last channel's GUARD completes.

Function
REQ-014 Each echo bit SHALL pass a 2-flop synchronizer; all echo decisions use the synchronized value.
REQ-015 Single FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, GUARD; one shared cycle counter, one channel index ch.
REQ-016 IDLE: if enable high, ch := 0, go TRIG next cycle; else remain.
REQ-017 TRIG: trigger[ch] high for exactly TRIG_CYC cycles, then WAIT_RISE; no other trigger bit ever high.
REQ-018 WAIT_RISE: synchronized echo[ch] high -> MEASURE with counter cleared; counter reaching RISE_TO_CYC -> record timeout, go GUARD.
REQ-019 MEASURE: count increments each cycle echo[ch] high; echo fall -> store count, valid=1, timeout=0, go GUARD.
REQ-020 MEASURE counter reaching ECHO_TO_CYC -> store count 30'h3FFF_FFFF, valid=1, timeout=1, go GUARD.
REQ-021 Timeout in WAIT_RISE SHALL store count 30'h3FFF_FFFF, valid=1, timeout=1.
REQ-022 GUARD: wait GUARD_CYC cycles; then if ch < N_CH-1, ch := ch+1, go TRIG; else pulse scan_done, ch := 0, go TRIG if enable else IDLE.
REQ-023 enable low mid-scan SHALL NOT abort: current channel completes through GUARD, then IDLE (scan_done only if ch was N_CH-1).
REQ-024 Echo already high on entry to WAIT_RISE (stuck line) SHALL be measured normally and bounded by ECHO_TO_CYC.
REQ-025 Stored result per channel SHALL update atomically in one cycle; rd_data is combinational from storage, so a read never shows a partial update.
REQ-026 Counts are unsigned; counters sized $clog2 of the largest timeout parameter; count field zero-extended to 30 bits.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, ch 0, counters 0, trigger all 0, scan_done 0.
REQ-028 reset_n low SHALL clear every channel's stored {valid, timeout, count} to 0; rd_data reads 0.
REQ-029 Reset mid-TRIG SHALL drop trigger within the same assertion, no glitch after release; release resumes from IDLE.

Structure
REQ-030 Package sonar_pkg SHALL hold the FSM state enum, the result struct {valid, timeout, count[29:0]}, and the saturation constant.
REQ-031 One sub-module sonar_sync (2-flop synchronizer, parametrised width) SHALL be used for echo.
REQ-032 Top level instantiates sonar_array once, replacing the four independent sonar instances; rd_data feeds DataToRPi for addresses 4..(3+N_CH).

Verification (sim params TRIG_CYC=5, RISE_TO_CYC=20, ECHO_TO_CYC=100, GUARD_CYC=10, N_CH=4)
REQ-033 enable=1, echo[0] high 40 cycles starting 3 cycles after trigger fall -> trigger[0] 5 cycles wide, ch0 rd_data = {1,0,30'd40}.
REQ-034 echo[2] never rises -> after 20 cycles in WAIT_RISE ch2 rd_data = 32'hFFFF_FFFF, scan proceeds to ch3.
REQ-035 echo[1] held high 200 cycles -> ch1 rd_data = 32'hFFFF_FFFF, FSM leaves MEASURE after 100 cycles.
REQ-036 Full scan all channels returning -> exactly one scan_done pulse after ch3 GUARD; trigger never multi-hot (assertion throughout).
REQ-037 enable dropped during ch1 MEASURE -> ch1 completes, FSM IDLE after GUARD, no trigger[2], no scan_done.
REQ-038 reset_n pulsed low mid-TRIG on ch0 -> trigger 0 immediately, all rd_data 0, rd_sel=7 reads 0.
